// File: rtl/vau_operand_sequencer_pkg.sv
// Shared definitions for the VAU operand sequencer.
//   state_t  : sequencer FSM states (4-bit encoding)
//   dbg_t    : debug view of the FSM (state + transfer index)
//   OFF_*    : VAU register offsets used by the sequencer
package vau_operand_sequencer_pkg;

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_REQ    = 4'd1,
      ST_RD_MEM = 4'd2,
      ST_WR_VAU = 4'd3,
      ST_SETTLE = 4'd4,
      ST_RD_VAU = 4'd5,
      ST_WR_MEM = 4'd6,
      ST_DONE   = 4'd7,
      ST_ERR    = 4'd8
   } state_t;

   // VAU register map: x1,y1,z1,x2,y2,z2 at 0-5, dot,crossX,crossY,crossZ at 6-9
   localparam logic [3:0] OFF_X1       = 4'd0;
   localparam logic [3:0] OFF_Z2       = 4'd5;
   localparam logic [3:0] OFF_DOT      = 4'd6;
   localparam logic [3:0] OFF_CZ       = 4'd9;
   localparam logic [3:0] OFF_UNMAPPED = 4'd10;

   typedef struct packed {
      state_t     state;
      logic [3:0] idx;
   } dbg_t;

   // States in which the sequencer owns the bus (when granted)
   function automatic logic is_bus_state(input state_t s);
      return (s == ST_RD_MEM) || (s == ST_WR_VAU) || (s == ST_SETTLE) ||
             (s == ST_RD_VAU) || (s == ST_WR_MEM);
   endfunction

endpackage

// File: rtl/vau_operand_sequencer_if.sv
// Arbitration and read-completion handshake between the sequencer and the bus.
//   busReq   : master -> arbiter, held high while the master wants the bus
//   busGrant : arbiter -> master, master may drive address/strobes/data only while high;
//              dropping it mid-transfer freezes the master until it returns
//   readDone : slave -> master, one-cycle pulse with read data valid on BUS that cycle
interface vau_operand_sequencer_if;
   logic busReq;
   logic busGrant;
   logic readDone;

   modport master (output busReq, input busGrant, input readDone);
   modport slave  (input busReq, output busGrant, output readDone);
endinterface

// File: rtl/vau_operand_sequencer_tristate.sv
// Generic tri-state driver: y follows d while en is high, otherwise floats.
//   en : drive enable
//   d  : value to drive
//   y  : tri-stated output net
module vau_operand_sequencer_tristate #(
   parameter int W = 1
) (
   input  logic         en,
   input  logic [W-1:0] d,
   output wire  [W-1:0] y
);
   assign y = en ? d : {W{1'bz}};
endmodule

// File: rtl/vau_operand_sequencer.sv
// Bus-master sequencer feeding the memory-mapped vector unit (VAU).
// On start it copies six operands RAM[srcAddr+0..5] -> VAU[0..5], waits
// SETTLE_CYCLES, then copies VAU[6..9] -> RAM[dstAddr+0..3].
//   CLOCK_50 / reset : clock, synchronous active-high reset
//   start            : one-cycle request, ignored while busy
//   srcAddr/dstAddr  : RAM operand/result base addresses, sampled on accepted start
//   bus_if           : busReq / busGrant / readDone handshake
//   BUS              : shared 16-bit data bus
//   address/writeEn/outputEn : tri-stated bus address and strobes
//   busy/done/error  : status; done and error are one-cycle pulses
//   dbg              : FSM state and transfer index
module vau_operand_sequencer
   import vau_operand_sequencer_pkg::*;
#(
   parameter logic [31:0] VAU_BASE      = 32'd0,
   parameter int unsigned SETTLE_CYCLES = 2,
   parameter int unsigned TIMEOUT       = 255
) (
   input  logic                           CLOCK_50,
   input  logic                           reset,
   input  logic                           start,
   input  logic [31:0]                    srcAddr,
   input  logic [31:0]                    dstAddr,
   vau_operand_sequencer_if.master        bus_if,
   inout  wire  [15:0]                    BUS,
   output wire  [31:0]                    address,
   output wire                            writeEn,
   output wire                            outputEn,
   output logic                           busy,
   output logic                           done,
   output logic                           error,
   output dbg_t                           dbg
);

   localparam logic [7:0] SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);
   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t      state_q, state_d;
   logic [3:0]  idx_q;
   logic [7:0]  cnt_q;
   logic [15:0] data_q;
   logic [31:0] src_q, dst_q;
   logic        grant, rd_done;
   logic        drive_ctl, drive_data;
   logic        we, oe;
   logic [31:0] addr;

   assign grant   = bus_if.busGrant;
   assign rd_done = bus_if.readDone;

   // FSM state register
   always_ff @(posedge CLOCK_50) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // Next state: every bus state holds while the grant is withdrawn
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:   if (start) state_d = ST_REQ;
         ST_REQ:    if (grant) state_d = ST_RD_MEM;
         ST_RD_MEM: if (grant) begin
            if (rd_done)                    state_d = ST_WR_VAU;
            else if (cnt_q == TIMEOUT_LAST) state_d = ST_ERR;
         end
         ST_WR_VAU: if (grant) state_d = (idx_q == OFF_Z2) ? ST_SETTLE : ST_RD_MEM;
         ST_SETTLE: if (grant && cnt_q == SETTLE_LAST) state_d = ST_RD_VAU;
         ST_RD_VAU: if (grant) begin
            if (rd_done)                    state_d = ST_WR_MEM;
            else if (cnt_q == TIMEOUT_LAST) state_d = ST_ERR;
         end
         ST_WR_MEM: if (grant) state_d = (idx_q == OFF_CZ) ? ST_DONE : ST_RD_VAU;
         ST_DONE:   state_d = ST_IDLE;
         ST_ERR:    state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Datapath: index, settle/timeout counter, captured data, latched addresses
   always_ff @(posedge CLOCK_50) begin
      if (reset) begin
         idx_q  <= OFF_X1;
         cnt_q  <= 8'd0;
         data_q <= 16'd0;
         src_q  <= 32'd0;
         dst_q  <= 32'd0;
      end else begin
         // Counter restarts on every state change and is frozen without grant
         if (state_d != state_q)
            cnt_q <= 8'd0;
         else if (grant && (state_q == ST_RD_MEM || state_q == ST_RD_VAU || state_q == ST_SETTLE))
            cnt_q <= cnt_q + 8'd1;

         case (state_q)
            ST_IDLE: if (start) begin
               src_q <= srcAddr;
               dst_q <= dstAddr;
               idx_q <= OFF_X1;
            end
            ST_RD_MEM, ST_RD_VAU: if (grant && rd_done) data_q <= BUS;
            ST_WR_VAU, ST_WR_MEM: if (grant) idx_q <= idx_q + 4'd1;
            default: ;
         endcase
      end
   end

   // Bus outputs; the index runs 0..9 across both phases so the result
   // slot in RAM is idx minus the first result offset
   always_comb begin
      addr = VAU_BASE + {28'd0, idx_q};
      we   = 1'b0;
      oe   = 1'b0;
      case (state_q)
         ST_RD_MEM: begin addr = src_q + {28'd0, idx_q}; oe = 1'b1; end
         ST_WR_VAU: we = 1'b1;
         ST_SETTLE: addr = VAU_BASE + {28'd0, OFF_UNMAPPED};
         ST_RD_VAU: oe = 1'b1;
         ST_WR_MEM: begin addr = dst_q + {28'd0, idx_q - OFF_DOT}; we = 1'b1; end
         default: ;
      endcase
   end

   assign drive_ctl  = grant && is_bus_state(state_q);
   assign drive_data = grant && (state_q == ST_WR_VAU || state_q == ST_WR_MEM);

   vau_operand_sequencer_tristate #(.W(32)) u_addr_drv (.en(drive_ctl),  .d(addr),   .y(address));
   vau_operand_sequencer_tristate #(.W(1))  u_we_drv   (.en(drive_ctl),  .d(we),     .y(writeEn));
   vau_operand_sequencer_tristate #(.W(1))  u_oe_drv   (.en(drive_ctl),  .d(oe),     .y(outputEn));
   vau_operand_sequencer_tristate #(.W(16)) u_bus_drv  (.en(drive_data), .d(data_q), .y(BUS));

   // Status
   always_comb begin
      bus_if.busReq = (state_q == ST_REQ) || is_bus_state(state_q);
      busy          = (state_q != ST_IDLE);
      done          = (state_q == ST_DONE);
      error         = (state_q == ST_ERR);
      dbg.state     = state_q;
      dbg.idx       = idx_q;
   end

endmodule

// File: tb/tb_vau_operand_sequencer.sv
module tb_vau_operand_sequencer;
   import vau_operand_sequencer_pkg::*;

   localparam logic [31:0] VAU_BASE = 32'h100;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] srcAddr, dstAddr;
   wire  [15:0] BUS;
   wire  [31:0] address;
   wire         writeEn, outputEn;
   logic        busy, done, error;
   dbg_t        dbg;

   always #5 clk = ~clk;

   vau_operand_sequencer_if bif();

   vau_operand_sequencer #(.VAU_BASE(VAU_BASE), .SETTLE_CYCLES(2), .TIMEOUT(255)) dut (
      .CLOCK_50(clk), .reset(reset), .start(start), .srcAddr(srcAddr), .dstAddr(dstAddr),
      .bus_if(bif), .BUS(BUS), .address(address), .writeEn(writeEn), .outputEn(outputEn),
      .busy(busy), .done(done), .error(error), .dbg(dbg)
   );

   // ---------------- RAM + VAU slave model ----------------
   logic [15:0] ram [0:1023];
   logic [15:0] vau_reg [0:5];
   logic        slave_oe;
   logic [15:0] slave_q;
   logic        ram_mute;
   logic        load_en;
   logic [9:0]  load_addr;
   logic [15:0] load_data;
   int          ram_writes = 0;

   assign BUS = slave_oe ? slave_q : 16'hzzzz;
   assign bif.readDone = slave_oe;

   function automatic logic [15:0] vau_read(input logic [3:0] off);
      logic [15:0] r;
      case (off)
         4'd6: r = vau_reg[0]*vau_reg[3] + vau_reg[1]*vau_reg[4] + vau_reg[2]*vau_reg[5];
         4'd7: r = vau_reg[1]*vau_reg[5] - vau_reg[2]*vau_reg[4];
         4'd8: r = vau_reg[2]*vau_reg[3] - vau_reg[0]*vau_reg[5];
         4'd9: r = vau_reg[0]*vau_reg[4] - vau_reg[1]*vau_reg[3];
         default: r = (off < 4'd6) ? vau_reg[off[2:0]] : 16'h0;
      endcase
      return r;
   endfunction

   always @(posedge clk) begin
      if (load_en) ram[load_addr] <= load_data;
      if (reset) begin
         slave_oe <= 1'b0;
      end else begin
         slave_oe <= 1'b0;
         if (outputEn === 1'b1 && !slave_oe) begin
            if (address >= VAU_BASE && address <= VAU_BASE + 32'd9) begin
               slave_oe <= 1'b1;
               slave_q  <= vau_read(4'(address - VAU_BASE));
            end else if (address >= 32'h200 && address < 32'h400 && !ram_mute) begin
               slave_oe <= 1'b1;
               slave_q  <= ram[address[9:0]];
            end
         end
         if (writeEn === 1'b1) begin
            if (address >= VAU_BASE && address < VAU_BASE + 32'd6)
               vau_reg[3'(address - VAU_BASE)] <= BUS;
            else if (address >= 32'h200 && address < 32'h400) begin
               ram[address[9:0]] <= BUS;
               ram_writes <= ram_writes + 1;
            end
         end
      end
   end

   // ---------------- pin monitor ----------------
   int busy_cycles = 0, done_cnt = 0, err_cnt = 0, drive_viol = 0, both_viol = 0;

   always @(negedge clk) begin
      if (busy)  busy_cycles = busy_cycles + 1;
      if (done)  done_cnt    = done_cnt + 1;
      if (error) err_cnt     = err_cnt + 1;
      if (!bif.busGrant && (writeEn === 1'b1 || outputEn === 1'b1)) drive_viol = drive_viol + 1;
      if (writeEn === 1'b1 && outputEn === 1'b1) both_viol = both_viol + 1;
   end

   // ---------------- scoreboard ----------------
   int n_tests = 0, n_fail = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic load_word(input logic [9:0] a, input logic [15:0] v);
      load_en = 1'b1; load_addr = a; load_data = v;
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic pulse_start(input logic [31:0] s, input logic [31:0] d);
      srcAddr = s; dstAddr = d; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int t = 0;
      while (busy && t < 2000) begin @(negedge clk); t++; end
      check({tag, "_idle"}, 32'(busy), 32'd0);
   endtask

   task automatic wait_state(input string tag, input state_t s, input logic [3:0] i);
      int t = 0;
      while (!(dbg.state == s && dbg.idx == i) && t < 500) begin @(negedge clk); t++; end
      check({tag, "_reach"}, 32'(dbg.state == s && dbg.idx == i), 32'd1);
   endtask

   task automatic check_results(input string tag, input logic [9:0] base,
                                input logic [15:0] r0, input logic [15:0] r1,
                                input logic [15:0] r2, input logic [15:0] r3);
      check({tag, "_dot"}, 32'(ram[base]),         32'(r0));
      check({tag, "_cx"},  32'(ram[base + 10'd1]), 32'(r1));
      check({tag, "_cy"},  32'(ram[base + 10'd2]), 32'(r2));
      check({tag, "_cz"},  32'(ram[base + 10'd3]), 32'(r3));
   endtask

   // ---------------- stimulus ----------------
   int b0, d0, e0, w0, v0;

   initial begin
      reset = 1'b1; start = 1'b0; srcAddr = 32'd0; dstAddr = 32'd0;
      bif.busGrant = 1'b1; ram_mute = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      repeat (3) @(negedge clk);

      // reset state
      check("rst_state",  32'(dbg.state), 32'(ST_IDLE));
      check("rst_busy",   32'(busy), 32'd0);
      check("rst_done",   32'(done), 32'd0);
      check("rst_error",  32'(error), 32'd0);
      check("rst_busreq", 32'(bif.busReq), 32'd0);
      check("rst_we",     32'(writeEn === 1'b1), 32'd0);
      reset = 1'b0;

      // memory image
      for (int i = 0; i < 6; i++) begin
         load_word(10'(32'h200 + i), 16'(i + 1));
         load_word(10'(32'h220 + i), 16'(i + 7));
      end
      load_word(10'h210, 16'h0100); load_word(10'h211, 16'h0000); load_word(10'h212, 16'h0000);
      load_word(10'h213, 16'h0100); load_word(10'h214, 16'h0000); load_word(10'h215, 16'h0000);
      for (int i = 32'h300; i < 32'h370; i++) load_word(10'(i), 16'hDEAD);

      // 1: basic run, grant held
      b0 = busy_cycles; d0 = done_cnt; e0 = err_cnt; w0 = ram_writes;
      pulse_start(32'h200, 32'h300);
      wait_idle("t1");
      check_results("t1", 10'h300, 16'd32, 16'hFFFD, 16'h0006, 16'hFFFD);
      check("t1_busy_cycles", 32'(busy_cycles - b0), 32'd34);
      check("t1_done",        32'(done_cnt - d0), 32'd1);
      check("t1_error",       32'(err_cnt - e0), 32'd0);
      check("t1_ram_writes",  32'(ram_writes - w0), 32'd4);

      // 2: dot product wraps to zero
      d0 = done_cnt;
      pulse_start(32'h210, 32'h310);
      wait_idle("t2");
      check_results("t2", 10'h310, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      check("t2_done", 32'(done_cnt - d0), 32'd1);

      // 3: RAM never answers -> timeout
      ram_mute = 1'b1;
      b0 = busy_cycles; d0 = done_cnt; e0 = err_cnt;
      pulse_start(32'h200, 32'h320);
      wait_idle("t3");
      ram_mute = 1'b0;
      check("t3_busy_cycles", 32'(busy_cycles - b0), 32'd257);
      check("t3_error",       32'(err_cnt - e0), 32'd1);
      check("t3_done",        32'(done_cnt - d0), 32'd0);
      check("t3_busreq",      32'(bif.busReq), 32'd0);
      check("t3_dst_untouched", 32'(ram[10'h320]), 32'hDEAD);

      // 4: grant withdrawn for 5 cycles at the first result read
      b0 = busy_cycles; d0 = done_cnt; v0 = drive_viol;
      pulse_start(32'h200, 32'h330);
      wait_state("t4", ST_RD_VAU, OFF_DOT);
      bif.busGrant = 1'b0;
      repeat (5) @(negedge clk);
      bif.busGrant = 1'b1;
      wait_idle("t4");
      check_results("t4", 10'h330, 16'd32, 16'hFFFD, 16'h0006, 16'hFFFD);
      check("t4_busy_cycles", 32'(busy_cycles - b0), 32'd39);
      check("t4_no_drive",    32'(drive_viol - v0), 32'd0);
      check("t4_done",        32'(done_cnt - d0), 32'd1);

      // 5: reset while writing operand 3
      d0 = done_cnt; e0 = err_cnt;
      pulse_start(32'h200, 32'h340);
      wait_state("t5", ST_WR_VAU, 4'd3);
      reset = 1'b1;
      @(negedge clk);
      check("t5_state",  32'(dbg.state), 32'(ST_IDLE));
      check("t5_idx",    32'(dbg.idx), 32'd0);
      check("t5_busy",   32'(busy), 32'd0);
      check("t5_busreq", 32'(bif.busReq), 32'd0);
      check("t5_oe",     32'(outputEn === 1'b1), 32'd0);
      reset = 1'b0;
      check("t5_no_pulse", 32'((done_cnt - d0) + (err_cnt - e0)), 32'd0);
      @(negedge clk);
      d0 = done_cnt; b0 = busy_cycles;
      pulse_start(32'h200, 32'h340);
      wait_idle("t5b");
      check_results("t5", 10'h340, 16'd32, 16'hFFFD, 16'h0006, 16'hFFFD);
      check("t5_done",        32'(done_cnt - d0), 32'd1);
      check("t5_busy_cycles", 32'(busy_cycles - b0), 32'd34);

      // 6: second start while busy is ignored
      b0 = busy_cycles; d0 = done_cnt; w0 = ram_writes;
      pulse_start(32'h200, 32'h350);
      repeat (10) @(negedge clk);
      pulse_start(32'h220, 32'h360);
      wait_idle("t6");
      repeat (3) @(negedge clk);
      check_results("t6", 10'h350, 16'd32, 16'hFFFD, 16'h0006, 16'hFFFD);
      check("t6_done",        32'(done_cnt - d0), 32'd1);
      check("t6_ram_writes",  32'(ram_writes - w0), 32'd4);
      check("t6_busy_cycles", 32'(busy_cycles - b0), 32'd34);
      check("t6_other_dst",   32'(ram[10'h360]), 32'hDEAD);
      check("t6_busy_after",  32'(busy), 32'd0);

      // strobes never overlap across the whole run
      check("strobe_overlap", 32'(both_viol), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
